grf_scoreboard: RTL and testbench

//  Parametrised general register file for the pipelined CPU.
//  - N-entry, WIDTH-bit register file; register 0 reads as zero.
//  - Write-first bypass: a same-cycle writeback value is visible on the read ports.
//  - Per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
//  - Registered writeback trace port; the testbench uses it instead of $display.

---
 rtl/grf_scoreboard.sv | 74 +++++++
 tb/tb_grf_scoreboard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: register file with write-first bypass, per-register pending-write scoreboard and writeback trace
module grf_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int PC_W   = 32,
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    rd_a1,
  input  logic [AW-1:0]    rd_a2,
  output logic [WIDTH-1:0] rd_d1,
  output logic [WIDTH-1:0] rd_d2,
  output logic             rd_busy1,
  output logic             rd_busy2,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [PC_W-1:0]  wb_pc,
  output logic             trc_valid,
  output logic [PC_W-1:0]  trc_pc,
  output logic [AW-1:0]    trc_addr,
  output logic [WIDTH-1:0] trc_data,
  output logic             err
);
  localparam int N = 2**AW;
  localparam logic [PEND_W-1:0] PMAX = '1;
  logic [WIDTH-1:0]  regs [N];
  logic [PEND_W-1:0] pend [N];
  logic              wb_go, iss_go, hit1, hit2;
  logic [PEND_W-1:0] p1, p2;
  assign wb_go  = wb_valid && wb_addr != '0;
  assign iss_ready = iss_addr == '0 || pend[iss_addr] != PMAX;
  assign iss_go = iss_valid && iss_ready && iss_addr != '0;
  always_comb begin
    hit1     = wb_valid && wb_addr == rd_a1;
    hit2     = wb_valid && wb_addr == rd_a2;
    rd_d1    = rd_a1 == '0 ? '0 : hit1 ? wb_data : regs[rd_a1];
    rd_d2    = rd_a2 == '0 ? '0 : hit2 ? wb_data : regs[rd_a2];
    p1       = pend[rd_a1] - PEND_W'(hit1 && pend[rd_a1] != '0);
    p2       = pend[rd_a2] - PEND_W'(hit2 && pend[rd_a2] != '0);
    rd_busy1 = rd_a1 != '0 && p1 != '0;
    rd_busy2 = rd_a2 != '0 && p2 != '0;
  end
  // a same-cycle reservation and retirement on one register cancel out in the counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      err       <= 1'b0;
      trc_valid <= 1'b0;
      trc_pc    <= '0;
      trc_addr  <= '0;
      trc_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wb_go && wb_addr == AW'(i)) regs[i] <= wb_data;
        pend[i] <= pend[i] + PEND_W'(iss_go && iss_addr == AW'(i))
                           - PEND_W'(wb_go && wb_addr == AW'(i) && pend[i] != '0);
      end
      if (wb_go && pend[wb_addr] == '0) err <= 1'b1;
      trc_valid <= wb_go;
      if (wb_go) begin
        trc_pc   <= wb_pc;
        trc_addr <= wb_addr;
        trc_data <= wb_data;
      end
    end
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed checks of bypass, scoreboard, trace, sticky error and async reset
module tb_grf_scoreboard;
  logic        clk = 0, reset_n = 0;
  logic [4:0]  rd_a1 = 0, rd_a2 = 0, iss_addr = 0, wb_addr = 0, trc_addr;
  logic [31:0] rd_d1, rd_d2, wb_data = 0, wb_pc = 0, trc_pc, trc_data;
  logic        rd_busy1, rd_busy2, iss_valid = 0, iss_ready, wb_valid = 0, trc_valid, err;
  int total = 0, bad = 0;

  grf_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_d1(rd_d1), .rd_d2(rd_d2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_pc(wb_pc), .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_addr(trc_addr),
    .trc_data(trc_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    for (int i = 0; i < 32; i++) begin
      rd_a1 = 5'(i); rd_a2 = 5'(31 - i); iss_addr = 5'(i);
      #1;
      total += 5;
      if (rd_d1 !== 0 || rd_d2 !== 0) begin bad++; $display("FAIL reset_rd a=%0d got %h/%h want 0", i, rd_d1, rd_d2); end
      if (rd_busy1 !== 0 || rd_busy2 !== 0) begin bad++; $display("FAIL reset_busy a=%0d got %b%b want 00", i, rd_busy1, rd_busy2); end
      if (iss_ready !== 1) begin bad++; $display("FAIL reset_ready a=%0d got %b want 1", i, iss_ready); end
      if (err !== 0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
      if (trc_valid !== 0) begin bad++; $display("FAIL reset_trc got %b want 0", trc_valid); end
    end
    @(negedge clk) reset_n = 1;
    rd_a1 = 0; rd_a2 = 0; iss_addr = 0;
    cyc();
  endtask

  task automatic test_bypass;
    iss_valid = 1; iss_addr = 5;
    cyc();
    iss_valid = 0; iss_addr = 0;
    wb_valid = 1; wb_addr = 5; wb_data = 32'h1234_5678; wb_pc = 32'h3000; rd_a1 = 5;
    #1;
    total += 2;
    if (rd_d1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_rd got %h want 12345678", rd_d1); end
    if (rd_busy1 !== 0) begin bad++; $display("FAIL bypass_busy got %b want 0", rd_busy1); end
    cyc();
    wb_valid = 0; wb_data = 0; wb_pc = 0;
    #1;
    total += 6;
    if (rd_d1 !== 32'h1234_5678) begin bad++; $display("FAIL reg_rd got %h want 12345678", rd_d1); end
    if (trc_valid !== 1) begin bad++; $display("FAIL trc_valid got %b want 1", trc_valid); end
    if (trc_pc !== 32'h3000) begin bad++; $display("FAIL trc_pc got %h want 3000", trc_pc); end
    if (trc_addr !== 5) begin bad++; $display("FAIL trc_addr got %0d want 5", trc_addr); end
    if (trc_data !== 32'h1234_5678) begin bad++; $display("FAIL trc_data got %h want 12345678", trc_data); end
    if (err !== 0) begin bad++; $display("FAIL bypass_err got %b want 0", err); end
    cyc();
    total++;
    if (trc_valid !== 0) begin bad++; $display("FAIL trc_drop got %b want 0", trc_valid); end
  endtask

  task automatic test_pending;
    rd_a1 = 8; iss_valid = 1; iss_addr = 8;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (iss_ready !== 1) begin bad++; $display("FAIL pend_ready k=%0d got %b want 1", k, iss_ready); end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      total += 2;
      if (iss_ready !== 0) begin bad++; $display("FAIL pend_full k=%0d got %b want 0", k, iss_ready); end
      if (rd_busy1 !== 1) begin bad++; $display("FAIL pend_busy k=%0d got %b want 1", k, rd_busy1); end
      cyc();
    end
    iss_valid = 0; iss_addr = 0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_addr = 8; wb_data = 32'h100 + 32'(k);
      #1;
      total += 2;
      if (rd_busy1 !== (k != 2)) begin bad++; $display("FAIL wb_busy k=%0d got %b want %b", k, rd_busy1, k != 2); end
      if (rd_d1 !== 32'h100 + 32'(k)) begin bad++; $display("FAIL wb_rd k=%0d got %h want %h", k, rd_d1, 32'h100 + k); end
      cyc();
    end
    wb_valid = 0;
    #1;
    total += 4;
    if (rd_busy1 !== 0) begin bad++; $display("FAIL drain_busy got %b want 0", rd_busy1); end
    if (iss_ready !== 1) begin bad++; $display("FAIL drain_ready got %b want 1", iss_ready); end
    if (err !== 0) begin bad++; $display("FAIL drain_err got %b want 0", err); end
    if (rd_d1 !== 32'h102) begin bad++; $display("FAIL drain_rd got %h want 102", rd_d1); end
  endtask

  task automatic test_cancel_zero;
    rd_a1 = 9; iss_valid = 1; iss_addr = 9;
    cyc();
    wb_valid = 1; wb_addr = 9; wb_data = 32'hAA;
    cyc();
    iss_valid = 0; iss_addr = 0; wb_valid = 0;
    #1;
    total += 2;
    if (rd_busy1 !== 1) begin bad++; $display("FAIL cancel_busy got %b want 1", rd_busy1); end
    if (err !== 0) begin bad++; $display("FAIL cancel_err got %b want 0", err); end
    wb_valid = 1; wb_data = 32'hBB;
    cyc();
    wb_valid = 0;
    #1;
    total += 2;
    if (rd_busy1 !== 0) begin bad++; $display("FAIL cancel_drain got %b want 0", rd_busy1); end
    if (err !== 0) begin bad++; $display("FAIL cancel_err2 got %b want 0", err); end
    rd_a1 = 0; rd_a2 = 0; wb_valid = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    #1;
    total++;
    if (rd_d1 !== 0 || rd_d2 !== 0) begin bad++; $display("FAIL r0_rd got %h/%h want 0", rd_d1, rd_d2); end
    cyc();
    wb_valid = 0; wb_data = 0;
    #1;
    total += 3;
    if (trc_valid !== 0) begin bad++; $display("FAIL r0_trc got %b want 0", trc_valid); end
    if (err !== 0) begin bad++; $display("FAIL r0_err got %b want 0", err); end
    if (rd_d1 !== 0) begin bad++; $display("FAIL r0_after got %h want 0", rd_d1); end
  endtask

  task automatic test_err_reset;
    rd_a1 = 3; rd_a2 = 4;
    wb_valid = 1; wb_addr = 3; wb_data = 32'hCAFE; wb_pc = 32'h40;
    iss_valid = 1; iss_addr = 4;
    cyc();
    wb_valid = 0; iss_addr = 3;
    #1;
    total += 3;
    if (err !== 1) begin bad++; $display("FAIL err_set got %b want 1", err); end
    if (rd_d1 !== 32'hCAFE) begin bad++; $display("FAIL err_rd got %h want cafe", rd_d1); end
    if (rd_busy2 !== 1) begin bad++; $display("FAIL err_busy4 got %b want 1", rd_busy2); end
    cyc();
    iss_valid = 0; iss_addr = 0; wb_valid = 1; wb_data = 32'hBEEF;
    cyc();
    wb_valid = 0;
    #1;
    total += 3;
    if (err !== 1) begin bad++; $display("FAIL err_sticky got %b want 1", err); end
    if (trc_valid !== 1) begin bad++; $display("FAIL err_trc got %b want 1", trc_valid); end
    if (rd_d1 !== 32'hBEEF) begin bad++; $display("FAIL err_rd2 got %h want beef", rd_d1); end
    #1 reset_n = 0;
    #1;
    total += 5;
    if (err !== 0) begin bad++; $display("FAIL arst_err got %b want 0", err); end
    if (rd_d1 !== 0) begin bad++; $display("FAIL arst_rd got %h want 0", rd_d1); end
    if (rd_busy2 !== 0) begin bad++; $display("FAIL arst_busy got %b want 0", rd_busy2); end
    if (trc_valid !== 0) begin bad++; $display("FAIL arst_trc got %b want 0", trc_valid); end
    if (trc_data !== 0) begin bad++; $display("FAIL arst_trcd got %h want 0", trc_data); end
    @(negedge clk) reset_n = 1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_pending();
    test_cancel_zero();
    test_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
